mc_control_fsm: RTL

- Multi-cycle sequencer for the MIPS datapath. It replaces the single-cycle decode with an FSM that steps each instruction through FETCH/DECODE/EXEC/MEM/WB over one shared instruction/data memory port.
- Handles memory wait states through a req/ready handshake and retires one instruction at a time.
- Counts retired instructions and traps on memory timeout or illegal opcode.

---
 rtl/mc_control_fsm.sv | 259 +++++++++++++++++++++++++
 1 files changed

// File: rtl/mc_control_fsm.sv
// Multi-cycle MIPS control sequencer: walks each instruction through FETCH/DECODE/EXEC/MEM/WB
// over a shared memory port, counts retirements and traps on bus timeout or illegal opcode.
module mc_control_fsm #(
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [5:0]       opcode,
  input  logic [5:0]       funct,
  input  logic             bcond,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             mem_we,
  output logic             iord,
  output logic             ir_write,
  output logic             pc_write,
  output logic [1:0]       pc_src,
  output logic             reg_write,
  output logic [1:0]       reg_dst,
  output logic             mem_to_reg,
  output logic [1:0]       alu_src,
  output logic [3:0]       alu_ctrl,
  output logic             retire,
  output logic [CNT_W-1:0] instr_count,
  output logic             bus_err,
  output logic             illegal,
  output logic [2:0]       state
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd7
  } state_e;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_JAL  = 6'b000011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_BNE  = 6'b000101;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_SLTI = 6'b001010;
  localparam logic [5:0] OP_ANDI = 6'b001100;
  localparam logic [5:0] OP_ORI  = 6'b001101;
  localparam logic [5:0] OP_XORI = 6'b001110;
  localparam logic [5:0] OP_LB   = 6'b100000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SB   = 6'b101000;
  localparam logic [5:0] OP_SW   = 6'b101011;

  localparam logic [5:0] F_SLL = 6'b000000;
  localparam logic [5:0] F_SRL = 6'b000010;
  localparam logic [5:0] F_JR  = 6'b001000;
  localparam logic [5:0] F_ADD = 6'b100000;
  localparam logic [5:0] F_SUB = 6'b100010;
  localparam logic [5:0] F_AND = 6'b100100;
  localparam logic [5:0] F_OR  = 6'b100101;
  localparam logic [5:0] F_XOR = 6'b100110;
  localparam logic [5:0] F_SLT = 6'b101010;

  // The wait counter trips in the TIMEOUT-th consecutive cycle without mem_ready.
  localparam logic [15:0] WAIT_LAST = 16'(TIMEOUT - 1);

  state_e           state_q, state_d;
  logic [15:0]      wait_q, wait_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             bus_err_q, bus_err_d;
  logic             illegal_q, illegal_d;

  logic       is_r, is_j, is_jal, is_jr, is_br, is_ld, is_st, is_legal;
  logic [3:0] dec_alu;
  logic [1:0] dec_src;

  logic       mem_req_s, mem_we_s, iord_s, ir_write_s, pc_write_s;
  logic       reg_write_s, mem_to_reg_s, retire_s;
  logic [1:0] pc_src_s, reg_dst_s, alu_src_s;
  logic [3:0] alu_ctrl_s;
  logic       wait_expired;

  always_comb begin
    is_r     = 1'b0;
    is_j     = 1'b0;
    is_jal   = 1'b0;
    is_jr    = 1'b0;
    is_br    = 1'b0;
    is_ld    = 1'b0;
    is_st    = 1'b0;
    is_legal = 1'b1;
    dec_alu  = 4'd15;
    dec_src  = 2'd0;
    case (opcode)
      OP_R: begin
        is_r = 1'b1;
        case (funct)
          F_ADD: dec_alu = 4'd0;
          F_AND: dec_alu = 4'd1;
          F_OR:  dec_alu = 4'd2;
          F_SLT: dec_alu = 4'd4;
          F_SUB: dec_alu = 4'd6;
          F_XOR: dec_alu = 4'd7;
          F_SLL: begin dec_alu = 4'd3; dec_src = 2'd2; end
          F_SRL: begin dec_alu = 4'd5; dec_src = 2'd2; end
          F_JR:  is_jr = 1'b1;
          default: is_legal = 1'b0;
        endcase
      end
      OP_J:    is_j = 1'b1;
      OP_JAL:  is_jal = 1'b1;
      OP_BEQ:  begin is_br = 1'b1; dec_alu = 4'd8; end
      OP_BNE:  begin is_br = 1'b1; dec_alu = 4'd9; end
      OP_ADDI: begin dec_alu = 4'd0; dec_src = 2'd1; end
      OP_ANDI: begin dec_alu = 4'd1; dec_src = 2'd1; end
      OP_ORI:  begin dec_alu = 4'd2; dec_src = 2'd1; end
      OP_SLTI: begin dec_alu = 4'd4; dec_src = 2'd1; end
      OP_XORI: begin dec_alu = 4'd7; dec_src = 2'd1; end
      OP_LB, OP_LW: begin is_ld = 1'b1; dec_alu = 4'd0; dec_src = 2'd1; end
      OP_SB, OP_SW: begin is_st = 1'b1; dec_alu = 4'd0; dec_src = 2'd1; end
      default: is_legal = 1'b0;
    endcase
  end

  assign wait_expired = (wait_q == WAIT_LAST);

  always_comb begin
    state_d      = state_q;
    wait_d       = 16'd0;
    bus_err_d    = bus_err_q;
    illegal_d    = illegal_q;
    mem_req_s    = 1'b0;
    mem_we_s     = 1'b0;
    iord_s       = 1'b0;
    ir_write_s   = 1'b0;
    pc_write_s   = 1'b0;
    pc_src_s     = 2'd0;
    reg_write_s  = 1'b0;
    reg_dst_s    = 2'd0;
    mem_to_reg_s = 1'b0;
    alu_src_s    = 2'd0;
    alu_ctrl_s   = 4'd0;
    retire_s     = 1'b0;
    case (state_q)
      S_FETCH: begin
        mem_req_s = 1'b1;
        if (mem_ready) begin
          ir_write_s = 1'b1;
          pc_write_s = 1'b1;
          state_d    = S_DECODE;
        end else if (wait_expired) begin
          bus_err_d = 1'b1;
          state_d   = S_HALT;
        end else begin
          wait_d = wait_q + 16'd1;
        end
      end
      S_DECODE: begin
        if (!is_legal) begin
          illegal_d = 1'b1;
          state_d   = S_HALT;
        end else if (is_j || is_jal) begin
          pc_write_s  = 1'b1;
          pc_src_s    = 2'd2;
          reg_write_s = is_jal;
          reg_dst_s   = is_jal ? 2'd2 : 2'd0;
          retire_s    = 1'b1;
          state_d     = S_FETCH;
        end else if (is_jr) begin
          pc_write_s = 1'b1;
          pc_src_s   = 2'd3;
          retire_s   = 1'b1;
          state_d    = S_FETCH;
        end else begin
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        alu_ctrl_s = dec_alu;
        alu_src_s  = dec_src;
        if (is_br) begin
          pc_write_s = bcond;
          pc_src_s   = 2'd1;
          retire_s   = 1'b1;
          state_d    = S_FETCH;
        end else if (is_ld || is_st) begin
          state_d = S_MEM;
        end else begin
          state_d = S_WB;
        end
      end
      S_MEM: begin
        mem_req_s = 1'b1;
        iord_s    = 1'b1;
        mem_we_s  = is_st;
        if (mem_ready) begin
          retire_s = is_st;
          state_d  = is_st ? S_FETCH : S_WB;
        end else if (wait_expired) begin
          bus_err_d = 1'b1;
          state_d   = S_HALT;
        end else begin
          wait_d = wait_q + 16'd1;
        end
      end
      S_WB: begin
        reg_write_s  = 1'b1;
        reg_dst_s    = is_r ? 2'd1 : 2'd0;
        mem_to_reg_s = is_ld;
        retire_s     = 1'b1;
        state_d      = S_FETCH;
      end
      S_HALT: begin
        wait_d = wait_q;
      end
      default: begin
        state_d = S_HALT;
      end
    endcase
  end

  assign cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, retire_s};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_FETCH;
      wait_q    <= 16'd0;
      cnt_q     <= {CNT_W{1'b0}};
      bus_err_q <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      cnt_q     <= cnt_d;
      bus_err_q <= bus_err_d;
      illegal_q <= illegal_d;
    end
  end

  // Strobes are forced low while reset is held so a mid-access reset drops mem_req at once.
  assign mem_req     = rst_n & mem_req_s;
  assign mem_we      = rst_n & mem_we_s;
  assign iord        = rst_n & iord_s;
  assign ir_write    = rst_n & ir_write_s;
  assign pc_write    = rst_n & pc_write_s;
  assign pc_src      = rst_n ? pc_src_s : 2'd0;
  assign reg_write   = rst_n & reg_write_s;
  assign reg_dst     = rst_n ? reg_dst_s : 2'd0;
  assign mem_to_reg  = rst_n & mem_to_reg_s;
  assign alu_src     = rst_n ? alu_src_s : 2'd0;
  assign alu_ctrl    = rst_n ? alu_ctrl_s : 4'd0;
  assign retire      = rst_n & retire_s;
  assign instr_count = cnt_q;
  assign bus_err     = bus_err_q;
  assign illegal     = illegal_q;
  assign state       = state_q;

endmodule
